multicycle_control_fsm: RTL

- Main control state machine for the multicycle RV32I core variant.
- Sequences one shared ALU, instruction/data memory port, register file and PC over several cycles per instruction.
- Drives ALU_Op into the existing ALU decoder and selects ALU operands per step.
- Stalls on a memory-ready handshake; flags illegal opcodes and bus timeouts.

---
 rtl/multicycle_control_fsm_if.sv | 30 +++
 rtl/multicycle_control_fsm.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Memory-port handshake bundle between the multicycle control FSM and the
// shared instruction/data memory.
//   mem_req   : FSM requests a memory access this cycle
//   mem_ready : memory completes the access this cycle
//   MemWrite  : access is a data write
//   AdrSrc    : address select, 0 PC, 1 ALUOut
//   bus_err   : one-cycle pulse, memory wait timed out
interface multicycle_control_fsm_if;
    logic mem_req;
    logic mem_ready;
    logic MemWrite;
    logic AdrSrc;
    logic bus_err;

    modport master (
        output mem_req,
        output MemWrite,
        output AdrSrc,
        output bus_err,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  MemWrite,
        input  AdrSrc,
        input  bus_err,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control state machine for the multicycle RV32I core. Sequences the
// shared ALU, memory port, register file and PC over several cycles per
// instruction, stalls on mem_ready and aborts a memory wait after
// BUS_TIMEOUT cycles.
//   clk        : core clock, rising edge
//   rst        : asynchronous active-low reset
//   op         : opcode field from the instruction register
//   Zero       : ALU zero flag (branch decision)
//   mem        : memory handshake bundle (master side)
//   ALU_Op     : 00 add, 01 subtract, 10 decode func3/func7
//   ALUSrcA    : 00 PC, 01 OldPC, 10 RD1
//   ALUSrcB    : 00 RD2, 01 ImmExt, 10 constant 4
//   ResultSrc  : 00 ALUOut, 01 memory data, 10 ALUResult
//   IRWrite, PCWrite, RegWrite : write enables
//   illegal_op : one-cycle pulse on an unsupported opcode
//   state_dbg  : current state encoding
module multicycle_control_fsm #(
    parameter int unsigned BUS_TIMEOUT = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [6:0]                      op,
    input  logic                            Zero,
    multicycle_control_fsm_if.master        mem,
    output logic [1:0]                      ALU_Op,
    output logic [1:0]                      ALUSrcA,
    output logic [1:0]                      ALUSrcB,
    output logic [1:0]                      ResultSrc,
    output logic                            IRWrite,
    output logic                            PCWrite,
    output logic                            RegWrite,
    output logic                            illegal_op,
    output logic [3:0]                      state_dbg
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic       mem_state;
    logic       timeout;
    logic       ir_w, pc_w, rw_w, mw_w, req_w, ill_w;

    always_comb begin
        mem_state = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
        timeout   = mem_state && !mem.mem_ready && (wait_cnt == 8'(BUS_TIMEOUT - 1));
    end

    // Outputs decode combinationally from the registered state because the
    // enables are qualified by mem_ready/Zero in the same cycle.
    always_comb begin
        state_next = state;
        ALU_Op     = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        mem.AdrSrc = 1'b0;
        ir_w       = 1'b0;
        pc_w       = 1'b0;
        rw_w       = 1'b0;
        mw_w       = 1'b0;
        req_w      = 1'b0;
        ill_w      = 1'b0;
        case (state)
            FETCH: begin
                req_w     = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_w      = mem.mem_ready;
                pc_w      = mem.mem_ready;
                if (mem.mem_ready) state_next = DECODE;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    7'b0000011, 7'b0100011: state_next = MEMADR;
                    7'b0110011:             state_next = EXECUTER;
                    7'b0010011:             state_next = EXECUTEI;
                    7'b1100011:             state_next = BEQ;
                    7'b1101111:             state_next = JAL;
                    default: begin
                        state_next = FETCH;
                        ill_w      = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = (op == 7'b0000011) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                mem.AdrSrc = 1'b1;
                req_w      = 1'b1;
                if (mem.mem_ready) state_next = MEMWB;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                rw_w       = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                mem.AdrSrc = 1'b1;
                req_w      = 1'b1;
                mw_w       = 1'b1;
                if (mem.mem_ready) state_next = FETCH;
            end
            EXECUTER: begin
                ALUSrcA    = 2'b10;
                ALU_Op     = 2'b10;
                state_next = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALU_Op     = 2'b10;
                state_next = ALUWB;
            end
            ALUWB: begin
                rw_w       = 1'b1;
                state_next = FETCH;
            end
            BEQ: begin
                ALUSrcA    = 2'b10;
                ALU_Op     = 2'b01;
                pc_w       = Zero;
                state_next = FETCH;
            end
            JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_w       = 1'b1;
                state_next = ALUWB;
            end
            default: state_next = FETCH;
        endcase

        if (timeout) state_next = FETCH;

        // A timed-out cycle commits no writes; reset gates every enable.
        IRWrite      = rst && ir_w && !timeout;
        PCWrite      = rst && pc_w && !timeout;
        RegWrite     = rst && rw_w && !timeout;
        mem.MemWrite = rst && mw_w && !timeout;
        mem.mem_req  = rst && req_w;
        illegal_op   = rst && ill_w;
        mem.bus_err  = rst && timeout;
        state_dbg    = state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= FETCH;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (timeout || (state_next != state) || mem.mem_ready)
                wait_cnt <= '0;
            else if (mem_state)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

endmodule
